// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO family: default sizes,
// pointer/count width derivation and parameter legality.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 16;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic bit params_legal(input int data_w, input int depth,
                                      input int af_thresh, input int ae_thresh);
    bit ok;
    ok = 1'b1;
    if (data_w < 1)                       ok = 1'b0;
    if (depth < 2)                        ok = 1'b0;
    if ((depth & (depth - 1)) != 0)       ok = 1'b0;
    if (af_thresh < 1 || af_thresh > depth)      ok = 1'b0;
    if (ae_thresh < 0 || ae_thresh > depth - 1)  ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/sync_fifo_ctl_if.sv
// Push/pop/status bundle of sync_fifo_ctl; slave is the FIFO, master the
// producer/consumer side.
interface sync_fifo_ctl_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
);
  logic                      push;
  logic [DATA_W-1:0]         data_in;
  logic                      pop;
  logic [DATA_W-1:0]         data_out;
  logic                      empty;
  logic                      full;
  logic                      almost_full;
  logic                      almost_empty;
  logic [cnt_w(DEPTH)-1:0]   count;
  logic                      overflow;
  logic                      underflow;

  modport master (
    output push, data_in, pop,
    input  data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_r [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO controller: pointers, occupancy count, threshold flags and
// overflow/underflow pulses. Define SYNC_FIFO_CTL_FWFT_EN for first-word-fall-through reads.
module sync_fifo_ctl
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_ctl_if.slave bus
);
  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  if (!params_legal(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_ctl: illegal parameters DATA_W=%0d DEPTH=%0d AF_THRESH=%0d AE_THRESH=%0d",
           DATA_W, DEPTH, AF_THRESH, AE_THRESH);
  end

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic              overflow_r;
  logic              underflow_r;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic              empty_s;
  logic              full_s;
  logic              almost_full_s;
  logic              almost_empty_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] data_out_s;

  fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (push_ok_s),
    .waddr (wr_ptr_r),
    .wdata (bus.data_in),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  // flag decode from the registered count only
  always_comb begin
    empty_s        = (count_r == {CNT_W{1'b0}});
    full_s         = (count_r == FULL_LVL);
    almost_full_s  = (count_r >= AF_LVL);
    almost_empty_s = (count_r <= AE_LVL);
  end

  // request acceptance and next occupancy
  always_comb begin
    push_ok_s = bus.push && !full_s;
    pop_ok_s  = bus.pop  && !empty_s;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // pointers, count and error pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {ADDR_W{1'b0}};
      rd_ptr_r    <= {ADDR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
      end
      count_r     <= count_nxt_s;
      overflow_r  <= bus.push && full_s;
      underflow_r <= bus.pop  && empty_s;
    end
  end

`ifdef SYNC_FIFO_CTL_FWFT_EN
  // head word is presented while the FIFO holds data
  always_comb begin
    if (empty_s) begin
      data_out_s = {DATA_W{1'b0}};
    end else begin
      data_out_s = rd_data_s;
    end
  end
`else
  logic [DATA_W-1:0] data_r;

  // registered read: capture the head word on an accepted pop, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {DATA_W{1'b0}};
    end else if (pop_ok_s) begin
      data_r <= rd_data_s;
    end
  end

  assign data_out_s = data_r;
`endif

  assign bus.data_out     = data_out_s;
  assign bus.empty        = empty_s;
  assign bus.full         = full_s;
  assign bus.almost_full  = almost_full_s;
  assign bus.almost_empty = almost_empty_s;
  assign bus.count        = count_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: doc/sync_fifo_ctl.md
# sync_fifo_ctl

Single-clock, parametrised FIFO: the same-domain successor to the team's async_fifo, for paths where producer and consumer share one clock. Data width, depth and threshold levels are generalised. Adds an occupancy count, almost-full and almost-empty thresholds, and overflow/underflow error pulses. An optional first-word-fall-through read mode is selected at compile time. Sits between any push-side producer and pop-side consumer in the datapath.

## Interface
- DATA_W, 32, data word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 2
- AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1

- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- push  in  1  write request
- data_in  in  DATA_W  write data, sampled with an accepted push
- pop  in  1  read request
- data_out  out  DATA_W  read data
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AF_THRESH
- almost_empty  out  1  count ≤ AE_THRESH
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  one-cycle pulse: a push was rejected
- underflow  out  1  one-cycle pulse: a pop was rejected

## Operation
- Storage is DEPTH×DATA_W. It is addressed by wr_ptr and rd_ptr, each $clog2(DEPTH) bits, which wrap naturally modulo DEPTH.
- A push is accepted iff push && !full. On acceptance, mem[wr_ptr] <= data_in and wr_ptr increments.
- A pop is accepted iff pop && !empty. On acceptance, rd_ptr increments.
- Acceptance is evaluated on the flags as registered before the edge.
  - When full, a simultaneous push and pop accepts the pop and rejects the push (overflow pulses).
  - When empty, a simultaneous push and pop accepts the push and rejects the pop (underflow pulses).
- Count update: count <= count + accepted_push − accepted_pop. When both are accepted, count is unchanged.
- All flags are decoded combinationally from the registered count.
- overflow and underflow are registered. Each asserts for exactly one cycle after the edge on which the rejected request was sampled, and reasserts on each further rejected cycle.
- Memory contents are never reset. Only pointers, count and outputs are reset.
- Reset is asynchronous. All reset values apply immediately and any stored data is discarded:
  - count = 0, empty = 1, almost_empty = 1
  - full = 0, almost_full = 0
  - overflow = 0, underflow = 0
  - data_out = 0
  - pointers = 0

## Timing
- Flags and count change one cycle after the edge that accepts the request.
- Standard read (macro absent):
  - data_out is registered: on an accepted pop, data_out <= mem[rd_ptr] at that edge.
  - Read latency is one cycle from the pop sample.
  - data_out holds its value while no pop is accepted.
- A push into an empty FIFO makes empty deassert on the next cycle. The earliest accepted pop is that cycle.
- No combinational path exists from push or pop to any output.

## Configuration
- SYNC_FIFO_CTL_FWFT_EN defined: first-word-fall-through.
  - data_out = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - An accepted pop acknowledges the presented word; the next word appears after that edge.
  - Zero read latency.
- Undefined: standard registered read, as in Timing.
- Flags, count and error pulses are identical in both modes.

## Structure
- Shared package fifo_pkg holds:
  - default DATA_W and DEPTH constants
  - the pointer/count width derivation (ADDR_W = $clog2(DEPTH), CNT_W = ADDR_W+1)
  - parameter-legality checks, reported as elaboration errors
- One sub-module, fifo_ram:
  - DEPTH×DATA_W register array
  - synchronous write port
  - asynchronous read port
- The control logic (pointers, count, flags, error pulses, read register) lives in sync_fifo_ctl.

## Test plan
Parameters DATA_W=32, DEPTH=16, AF_THRESH=14, AE_THRESH=2; standard mode unless stated.

- **Fill:** reset, then push 1..16 on consecutive cycles.
  - almost_empty deasserts when count reaches 3.
  - almost_full asserts when count reaches 14.
  - full = 1 and count = 16 after the 16th push.
- **Overflow:** from full, push 99.
  - overflow pulses for exactly one cycle; count stays 16.
  - Then pop 16 times: data_out returns 1..16 in order, one cycle after each pop. 99 never appears.
- **Underflow:** when empty, pop twice.
  - underflow is high for two cycles, count = 0, data_out holds its last value.
- **Simultaneous push/pop:**
  - At count = 5: count stays 5 and FIFO order is preserved.
  - At full: the pop is accepted, overflow pulses, and count drops to 15.
- **Wrap-around:** push and pop 10 words, then push 100..115.
  - full asserts, and the pops return 100..115 in order across the pointer wrap.
- **Reset mid-stream and FWFT:** assert rst at count = 7.
  - Immediately: empty = 1, count = 0, data_out = 0.
  - With SYNC_FIFO_CTL_FWFT_EN, a push of 42 shows data_out = 42 one cycle later, with no pop issued.
